row_seq_driver: RTL and testbench
=================================

# row_seq_driver

Parametrised, sequenced wordline driver for the CIM/CAM array. It replaces the combinational 4-row decoder with a registered request/response engine. The engine accepts one operation at a time: MAC read, CAM search or write. For each operation it drives a precharge phase, then a fixed-width wordline pulse, then a completion strobe. It sits between the macro controller and the bitcell array and drives WL/WLB for ROWS rows.

## Interface
- ROWS, 4: number of array rows; power of two, at least 2.
- ADDR_W, $clog2(ROWS): row address width.
- PRE_CYC, 1: precharge cycles before the wordline pulse; 0 skips precharge.
- PULSE_CYC, 2: wordline pulse width in cycles; at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  operation request.
- req_ready  out  1  high only in IDLE.
- req_mode  in  2  operation: 00 MAC read, 01 CAM search, 10 write, 11 reserved.
- req_addr  in  ADDR_W  target row (MAC read, write).
- req_data  in  ROWS  search key (CAM search); row mask when ROW_SEQ_MULTIROW_EN is set.
- WL  out  ROWS  wordlines.
- WLB  out  ROWS  complementary/second-port wordlines.
- precharge_en  out  1  bitline precharge enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion strobe.
- err  out  1  valid with done; high when the completed request used the reserved mode.

## Operation
- States: IDLE, PRE, PULSE, DONE.
- A request is accepted when req_valid && req_ready are both high at a rising edge. On acceptance, mode, addr and data are captured into registers. Input changes after acceptance have no effect.
- IDLE → PRE on accept when PRE_CYC > 0. Otherwise IDLE → PULSE. A reserved-mode request goes IDLE → DONE.
- PRE holds for PRE_CYC cycles, then moves to PULSE.
- PULSE holds for PULSE_CYC cycles, then moves to DONE.
- DONE lasts one cycle, then returns to IDLE.
- Wordline values during PULSE only. In all other states WL = 0 and WLB = 0.
  - MAC read: WL = onehot(addr); WLB = 0.
  - CAM search: WL = data; WLB = ~data (every row driven).
  - write: WL = onehot(addr); WLB = onehot(addr).
- precharge_en = 1 only in PRE.
- done = 1 only in DONE.
- err = 1 only in DONE, and only when the captured mode is 11.
- A single phase counter is shared by PRE and PULSE. Its width is $clog2(max(PRE_CYC, PULSE_CYC) + 1). It reloads on each state entry and never wraps.

## Timing
- All outputs are registered. Reset value of every output is 0 except req_ready, which is 1.
- Accept at edge T:
  - precharge_en high in cycles T+1 … T+PRE_CYC.
  - WL/WLB valid in the next PULSE_CYC cycles.
  - done in the cycle after that.
  - req_ready returns high the cycle after done.
- Occupancy is PRE_CYC + PULSE_CYC + 1 cycles. Minimum issue interval is PRE_CYC + PULSE_CYC + 2 cycles.
- req_valid while busy is ignored; no queueing. The requester must hold req_valid until it sees req_ready.
- rst_n low at any edge, mid-operation included: next cycle is IDLE, WL/WLB/precharge_en/done/err = 0, and the operation is dropped with no done.
- Precharge and wordline are never high in the same cycle. WL never changes during a pulse.

## Configuration
- ROW_SEQ_MULTIROW_EN defined: in MAC read, WL = captured req_data (multi-row MAC activation), and req_addr is ignored. WLB = 0 is unchanged.
- Undefined: MAC read drives onehot(addr) only, and req_data is ignored for MAC read.
- CAM search and write behave the same in both builds.

## Structure
- Shared package row_seq_pkg holds:
  - enum row_mode_t (MODE_MAC, MODE_CAM, MODE_WR, MODE_RSVD);
  - enum row_state_t (IDLE, PRE, PULSE, DONE).
- Sub-module row_addr_onehot: combinational ADDR_W → ROWS one-hot decoder. It is instantiated once on the captured address.
- Top level contains the FSM, capture registers, phase counter and output registers.

## Test plan
Defaults ROWS=4, PRE_CYC=1, PULSE_CYC=2 unless noted.
- MAC read, addr=2, data=0000, accepted at T:
  - precharge_en at T+1; WL=0100, WLB=0000 at T+2..T+3; done at T+4.
  - Changing data/addr at T+1 does not alter WL.
- CAM search, data=1010:
  - WL=1010, WLB=0101 for 2 cycles; done; err=0.
- Write, addr=3: WL=1000 and WLB=1000 during pulse.
- Reserved mode 11: done with err=1 one cycle after accept; WL, WLB and precharge_en stay 0 throughout.
- rst_n low during PULSE:
  - next cycle WL=0, busy=0, req_ready=1, no done;
  - a new MAC read to addr=1 then completes normally.
- PRE_CYC=0, PULSE_CYC=1:
  - WL valid at T+1, done at T+2, no precharge.
  - With ROW_SEQ_MULTIROW_EN, MAC read with data=0110 gives WL=0110.

Source files
------------

// File: rtl/row_seq_pkg.sv
// row_seq_pkg: shared types for the sequenced wordline driver.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: row_mode_t (operation encoding), row_state_t (FSM states), max2().
package row_seq_pkg;

   typedef enum logic [1:0] {
      MODE_MAC  = 2'b00,
      MODE_CAM  = 2'b01,
      MODE_WR   = 2'b10,
      MODE_RSVD = 2'b11
   } row_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRE   = 2'b01,
      PULSE = 2'b10,
      DONE  = 2'b11
   } row_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/row_addr_onehot.sv
// row_addr_onehot: combinational row address to one-hot row select decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_addr (ADDR_W) row index in; o_onehot (ROWS) one-hot row select out.
module row_addr_onehot #(
   parameter int ROWS   = 4,
   parameter int ADDR_W = $clog2(ROWS)
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ROWS-1:0]   o_onehot
);

   // ROWS is a power of two, so every address value selects a real row.
   always_comb begin
      o_onehot         = '0;
      o_onehot[i_addr] = 1'b1;
   end

endmodule

// File: rtl/row_seq_driver.sv
// row_seq_driver: sequenced WL/WLB driver for the CIM/CAM array (precharge, pulse, done).
// Latency: accept at edge T -> precharge T+1..T+PRE_CYC, WL for PULSE_CYC cycles, done one cycle later.
// Backpressure: req_ready high only in IDLE; requests while busy are ignored, never queued.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_mode/req_addr/req_data request;
//        WL/WLB wordlines, precharge_en, busy, done, err (all registered).
// Build option: define ROW_SEQ_MULTIROW_EN to drive WL from the captured req_data mask on MAC read.
module row_seq_driver
   import row_seq_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int ADDR_W    = $clog2(ROWS),
   parameter int PRE_CYC   = 1,
   parameter int PULSE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_mode,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ROWS-1:0]   req_data,
   output logic [ROWS-1:0]   WL,
   output logic [ROWS-1:0]   WLB,
   output logic              precharge_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Counter holds "cycles remaining minus one" in the current phase, so it
   // never needs to represent more than max(PRE_CYC, PULSE_CYC).
   localparam int CNT_W = $clog2(max2(PRE_CYC, PULSE_CYC) + 1);
   localparam logic [CNT_W-1:0] PRE_LD   = (PRE_CYC > 0) ? CNT_W'(PRE_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

   row_state_t        r_state;
   row_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   row_mode_t         r_mode;
   logic [ADDR_W-1:0] r_addr;
   logic [ROWS-1:0]   r_data;

   logic              r_ready;
   logic              r_busy;
   logic              r_pre;
   logic              r_done;
   logic              r_err;
   logic [ROWS-1:0]   r_wl;
   logic [ROWS-1:0]   r_wlb;

   logic              w_accept;
   row_mode_t         w_mode;
   logic [ADDR_W-1:0] w_addr;
   logic [ROWS-1:0]   w_data;
   logic [ROWS-1:0]   w_onehot;
   logic [ROWS-1:0]   w_wl_op;
   logic [ROWS-1:0]   w_wlb_op;

   assign w_accept = req_valid && r_ready;

   // Outputs are registered from the next state, so with PRE_CYC=0 the pulse
   // starts on the accept edge itself; the operand in flight on that edge is
   // the one being captured, afterwards it is the captured copy.
   always_comb begin
      w_mode = r_mode;
      w_addr = r_addr;
      w_data = r_data;
      if (w_accept) begin
         w_mode = row_mode_t'(req_mode);
         w_addr = req_addr;
         w_data = req_data;
      end
   end

   row_addr_onehot #(
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_onehot (
      .i_addr   (w_addr),
      .o_onehot (w_onehot)
   );

   // Wordline pattern applied while in PULSE.
   always_comb begin
      w_wl_op  = '0;
      w_wlb_op = '0;
      case (w_mode)
         MODE_MAC: begin
`ifdef ROW_SEQ_MULTIROW_EN
            w_wl_op = w_data;
`else
            w_wl_op = w_onehot;
`endif
         end
         MODE_CAM: begin
            w_wl_op  = w_data;
            w_wlb_op = ~w_data;
         end
         MODE_WR: begin
            w_wl_op  = w_onehot;
            w_wlb_op = w_onehot;
         end
         default: ;
      endcase
   end

   // Next-state and phase counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_mode == MODE_RSVD) begin
                  w_state_nxt = DONE;
               end else if (PRE_CYC > 0) begin
                  w_state_nxt = PRE;
                  w_cnt_nxt   = PRE_LD;
               end else begin
                  w_state_nxt = PULSE;
                  w_cnt_nxt   = PULSE_LD;
               end
            end
         end
         PRE: begin
            if (r_cnt == '0) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = PULSE_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mode  <= MODE_MAC;
         r_addr  <= '0;
         r_data  <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_pre   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_wl    <= '0;
         r_wlb   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_mode <= row_mode_t'(req_mode);
            r_addr <= req_addr;
            r_data <= req_data;
         end
         r_ready <= (w_state_nxt == IDLE);
         r_busy  <= (w_state_nxt != IDLE);
         r_pre   <= (w_state_nxt == PRE);
         r_done  <= (w_state_nxt == DONE);
         r_err   <= (w_state_nxt == DONE) && (w_mode == MODE_RSVD);
         r_wl    <= (w_state_nxt == PULSE) ? w_wl_op  : '0;
         r_wlb   <= (w_state_nxt == PULSE) ? w_wlb_op : '0;
      end
   end

   assign req_ready    = r_ready;
   assign busy         = r_busy;
   assign precharge_en = r_pre;
   assign done         = r_done;
   assign err          = r_err;
   assign WL           = r_wl;
   assign WLB          = r_wlb;

endmodule

// File: tb/tb_row_seq_driver.sv
// tb_row_seq_driver: directed bench for row_seq_driver (default and PRE_CYC=0/PULSE_CYC=1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_row_seq_driver;

   logic       clk;
   logic       rst_n;

   logic       a_valid, a_ready, a_pre, a_busy, a_done, a_err;
   logic [1:0] a_mode;
   logic [1:0] a_addr;
   logic [3:0] a_data, a_wl, a_wlb;

   logic       b_valid, b_ready, b_pre, b_busy, b_done, b_err;
   logic [1:0] b_mode;
   logic [1:0] b_addr;
   logic [3:0] b_data, b_wl, b_wlb;

   int errors = 0;
   int checks = 0;

`ifdef ROW_SEQ_MULTIROW_EN
   localparam logic [3:0] EXP_SHORT_WL = 4'b0110;
`else
   localparam logic [3:0] EXP_SHORT_WL = 4'b0010;
`endif

   row_seq_driver #(.ROWS(4), .PRE_CYC(1), .PULSE_CYC(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_ready(a_ready), .req_mode(a_mode),
      .req_addr(a_addr), .req_data(a_data),
      .WL(a_wl), .WLB(a_wlb), .precharge_en(a_pre),
      .busy(a_busy), .done(a_done), .err(a_err)
   );

   row_seq_driver #(.ROWS(4), .PRE_CYC(0), .PULSE_CYC(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready), .req_mode(b_mode),
      .req_addr(b_addr), .req_data(b_data),
      .WL(b_wl), .WLB(b_wlb), .precharge_en(b_pre),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one request for a single edge; returns at the negedge of cycle T+1.
   task automatic issue_a(input logic [1:0] m, input logic [1:0] ad, input logic [3:0] d);
      @(negedge clk);
      a_valid = 1'b1; a_mode = m; a_addr = ad; a_data = d;
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic issue_b(input logic [1:0] m, input logic [1:0] ad, input logic [3:0] d);
      @(negedge clk);
      b_valid = 1'b1; b_mode = m; b_addr = ad; b_data = d;
      @(negedge clk);
      b_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({a_ready, a_busy, a_pre, a_done, a_err} !== 5'b10000) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", {a_ready, a_busy, a_pre, a_done, a_err}, 5'b10000); end
      checks++; if ({a_wl, a_wlb} !== 8'h00) begin errors++; $display("FAIL reset_wl got=%h exp=%h", {a_wl, a_wlb}, 8'h00); end
      checks++; if ({b_ready, b_busy, b_pre, b_done, b_err, b_wl, b_wlb} !== 13'h1000) begin errors++; $display("FAIL reset_b got=%h exp=%h", {b_ready, b_busy, b_pre, b_done, b_err, b_wl, b_wlb}, 13'h1000); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mac_read;
      issue_a(2'b00, 2'd2, 4'b0000);
      checks++; if ({a_pre, a_busy, a_ready} !== 3'b110) begin errors++; $display("FAIL mac_c1_pre got=%b exp=%b", {a_pre, a_busy, a_ready}, 3'b110); end
      checks++; if (a_wl !== 4'b0000) begin errors++; $display("FAIL mac_c1_wl got=%b exp=%b", a_wl, 4'b0000); end
      a_addr = 2'd0; a_data = 4'hF;
      @(negedge clk);
      checks++; if ({a_wl, a_wlb, a_pre} !== {4'b0100, 4'b0000, 1'b0}) begin errors++; $display("FAIL mac_c2_wl got=%b exp=%b", {a_wl, a_wlb, a_pre}, {4'b0100, 4'b0000, 1'b0}); end
      @(negedge clk);
      checks++; if ({a_wl, a_wlb} !== {4'b0100, 4'b0000}) begin errors++; $display("FAIL mac_c3_wl got=%b exp=%b", {a_wl, a_wlb}, {4'b0100, 4'b0000}); end
      @(negedge clk);
      checks++; if ({a_done, a_err, a_wl} !== {1'b1, 1'b0, 4'b0000}) begin errors++; $display("FAIL mac_c4_done got=%b exp=%b", {a_done, a_err, a_wl}, {1'b1, 1'b0, 4'b0000}); end
      @(negedge clk);
      checks++; if ({a_ready, a_busy, a_done} !== 3'b100) begin errors++; $display("FAIL mac_c5_idle got=%b exp=%b", {a_ready, a_busy, a_done}, 3'b100); end
   endtask

   task automatic test_cam_search;
      issue_a(2'b01, 2'd0, 4'b1010);
      checks++; if ({a_pre, a_wl} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL cam_c1 got=%b exp=%b", {a_pre, a_wl}, {1'b1, 4'b0000}); end
      @(negedge clk);
      checks++; if ({a_wl, a_wlb} !== {4'b1010, 4'b0101}) begin errors++; $display("FAIL cam_c2_wl got=%b exp=%b", {a_wl, a_wlb}, {4'b1010, 4'b0101}); end
      @(negedge clk);
      checks++; if ({a_wl, a_wlb} !== {4'b1010, 4'b0101}) begin errors++; $display("FAIL cam_c3_wl got=%b exp=%b", {a_wl, a_wlb}, {4'b1010, 4'b0101}); end
      @(negedge clk);
      checks++; if ({a_done, a_err, a_wl, a_wlb} !== {2'b10, 8'h00}) begin errors++; $display("FAIL cam_c4_done got=%b exp=%b", {a_done, a_err, a_wl, a_wlb}, {2'b10, 8'h00}); end
      @(negedge clk);
   endtask

   task automatic test_write;
      issue_a(2'b10, 2'd3, 4'b0000);
      @(negedge clk);
      checks++; if ({a_wl, a_wlb} !== {4'b1000, 4'b1000}) begin errors++; $display("FAIL wr_c2_wl got=%b exp=%b", {a_wl, a_wlb}, {4'b1000, 4'b1000}); end
      @(negedge clk);
      checks++; if ({a_wl, a_wlb, a_pre} !== {4'b1000, 4'b1000, 1'b0}) begin errors++; $display("FAIL wr_c3_wl got=%b exp=%b", {a_wl, a_wlb, a_pre}, {4'b1000, 4'b1000, 1'b0}); end
      @(negedge clk);
      checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL wr_c4_done got=%b exp=%b", {a_done, a_err}, 2'b10); end
      @(negedge clk);
   endtask

   task automatic test_reserved;
      issue_a(2'b11, 2'd1, 4'b1111);
      checks++; if ({a_done, a_err, a_pre, a_wl, a_wlb} !== {3'b110, 8'h00}) begin errors++; $display("FAIL rsvd_c1 got=%b exp=%b", {a_done, a_err, a_pre, a_wl, a_wlb}, {3'b110, 8'h00}); end
      @(negedge clk);
      checks++; if ({a_ready, a_done, a_err, a_pre, a_wl} !== {4'b1000, 4'h0}) begin errors++; $display("FAIL rsvd_c2 got=%b exp=%b", {a_ready, a_done, a_err, a_pre, a_wl}, {4'b1000, 4'h0}); end
   endtask

   task automatic test_reset_mid;
      issue_a(2'b00, 2'd2, 4'b0000);
      @(negedge clk);
      checks++; if (a_wl !== 4'b0100) begin errors++; $display("FAIL rstmid_pulse got=%b exp=%b", a_wl, 4'b0100); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({a_wl, a_busy, a_ready, a_done} !== {4'b0000, 3'b010}) begin errors++; $display("FAIL rstmid_after got=%b exp=%b", {a_wl, a_busy, a_ready, a_done}, {4'b0000, 3'b010}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({a_done, a_busy} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone got=%b exp=%b", {a_done, a_busy}, 2'b00); end
      issue_a(2'b00, 2'd1, 4'b0000);
      @(negedge clk);
      checks++; if (a_wl !== 4'b0010) begin errors++; $display("FAIL rstmid_new_wl got=%b exp=%b", a_wl, 4'b0010); end
      repeat (2) @(negedge clk);
      checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL rstmid_new_done got=%b exp=%b", {a_done, a_err}, 2'b10); end
      @(negedge clk);
   endtask

   task automatic test_short_phase;
      issue_b(2'b00, 2'd1, 4'b0110);
      checks++; if ({b_wl, b_wlb, b_pre, b_busy} !== {EXP_SHORT_WL, 4'b0000, 2'b01}) begin errors++; $display("FAIL short_c1 got=%b exp=%b", {b_wl, b_wlb, b_pre, b_busy}, {EXP_SHORT_WL, 4'b0000, 2'b01}); end
      @(negedge clk);
      checks++; if ({b_done, b_err, b_wl, b_pre} !== {2'b10, 4'b0000, 1'b0}) begin errors++; $display("FAIL short_c2 got=%b exp=%b", {b_done, b_err, b_wl, b_pre}, {2'b10, 4'b0000, 1'b0}); end
      @(negedge clk);
      checks++; if ({b_ready, b_busy} !== 2'b10) begin errors++; $display("FAIL short_c3 got=%b exp=%b", {b_ready, b_busy}, 2'b10); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      a_valid = 1'b1; a_mode = 2'b01; a_addr = 2'd0; a_data = 4'b0011;
      @(negedge clk);
      checks++; if ({a_pre, a_ready} !== 2'b10) begin errors++; $display("FAIL b2b_c1 got=%b exp=%b", {a_pre, a_ready}, 2'b10); end
      @(negedge clk);
      checks++; if ({a_wl, a_wlb, a_ready} !== {4'b0011, 4'b1100, 1'b0}) begin errors++; $display("FAIL b2b_c2 got=%b exp=%b", {a_wl, a_wlb, a_ready}, {4'b0011, 4'b1100, 1'b0}); end
      repeat (2) @(negedge clk);
      checks++; if ({a_done, a_ready} !== 2'b10) begin errors++; $display("FAIL b2b_c4 got=%b exp=%b", {a_done, a_ready}, 2'b10); end
      @(negedge clk);
      checks++; if ({a_ready, a_busy, a_done} !== 3'b100) begin errors++; $display("FAIL b2b_c5 got=%b exp=%b", {a_ready, a_busy, a_done}, 3'b100); end
      @(negedge clk);
      a_valid = 1'b0;
      checks++; if ({a_pre, a_busy, a_ready} !== 3'b110) begin errors++; $display("FAIL b2b_c6 got=%b exp=%b", {a_pre, a_busy, a_ready}, 3'b110); end
      repeat (3) @(negedge clk);
      checks++; if ({a_done, a_err} !== 2'b10) begin errors++; $display("FAIL b2b_c9 got=%b exp=%b", {a_done, a_err}, 2'b10); end
      @(negedge clk);
      checks++; if ({a_ready, a_busy} !== 2'b10) begin errors++; $display("FAIL b2b_c10 got=%b exp=%b", {a_ready, a_busy}, 2'b10); end
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 1'b0; a_mode = 2'b00; a_addr = 2'd0; a_data = 4'h0;
      b_valid = 1'b0; b_mode = 2'b00; b_addr = 2'd0; b_data = 4'h0;
      test_reset();
      test_mac_read();
      test_cam_search();
      test_write();
      test_reserved();
      test_reset_mid();
      test_short_phase();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
